event_readout_ctrl: RTL and testbench



---
 rtl/bpm_readout_defs.sv | 29 ++
 rtl/rise_detect.sv | 32 +++
 rtl/event_readout_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_event_readout_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpm_readout_defs.sv
// Shared definitions for the BPM event readout path: FSM encoding and frame layout.
// The host-side frame decoder imports the same package.
package bpm_readout_defs;

    typedef enum logic [3:0] {
        StIdle,
        StHdrSync,
        StHdrEvt,
        StRdReq,
        StRdWait,
        StSend,
        StDiscard,
        StTrlCnt,
        StTrlSum,
        StDone
    } state_e;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

    // Frame: sync, event number, payload..., count trailer, checksum trailer.
    localparam int unsigned FRAME_HDR_WORDS = 2;
    localparam int unsigned FRAME_TRL_WORDS = 2;

    // Count trailer is {trunc, zero pad, payload count}; trunc sits in the MSB.
    function automatic int unsigned trunc_bit(input int unsigned data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registered copy of the input plus an AND-NOT against its
// previous value. level_o is the registered level used for re-arm decisions.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        sync_d = d_i;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/event_readout_ctrl.sv
// Drains one event from the FIFO per event_rdy rise and sends it to the host link as
// a frame: sync, event number, payload, {trunc, count} trailer, XOR checksum.
module event_readout_ctrl
    import bpm_readout_defs::*;
#(
    parameter int unsigned          DATA_W    = 16,
    parameter int unsigned          MAX_WORDS = 1024,
    parameter logic [DATA_W-1:0]    SYNC_WORD = DATA_W'(SYNC_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              event_rdy,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic [15:0]       evt_count
);

    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int unsigned TRUNC_BIT = trunc_bit(DATA_W);

    if (CNT_W >= DATA_W) begin : g_bad_cfg
        $error("MAX_WORDS does not fit below the trunc bit of DATA_W");
    end

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                tx_last_q, tx_last_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                trunc_q, trunc_d;
    logic [15:0]         evt_q, evt_d;

    logic                rdy_level;
    logic                rdy_rise;
    logic                hs;
    logic [DATA_W-1:0]   trl_cnt_word;

    rise_detect u_rdy_rise (
        .clk     (clk),
        .rst     (rst),
        .d_i     (event_rdy),
        .level_o (rdy_level),
        .rise_o  (rdy_rise)
    );

    assign hs = tx_valid_q & tx_ready;

    always_comb begin
        trl_cnt_word            = '0;
        trl_cnt_word[CNT_W-1:0] = cnt_q;
        trl_cnt_word[TRUNC_BIT] = trunc_q;
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        trunc_d    = trunc_q;
        evt_d      = evt_q;
        fifo_rd    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rdy_rise) begin
                    tx_data_d  = SYNC_WORD;
                    tx_valid_d = 1'b1;
                    state_d    = StHdrSync;
                end
            end
            StHdrSync: begin
                if (hs) begin
                    tx_data_d = DATA_W'(evt_q);
                    state_d   = StHdrEvt;
                end
            end
            StHdrEvt: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = StRdReq;
                end
            end
            StRdReq: begin
                if (fifo_empty) begin
                    tx_data_d  = trl_cnt_word;
                    tx_valid_d = 1'b1;
                    state_d    = StTrlCnt;
                end else if (cnt_q == CNT_W'(MAX_WORDS)) begin
                    trunc_d = 1'b1;
                    state_d = StDiscard;
                end else begin
                    fifo_rd = 1'b1;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                tx_data_d  = fifo_dout;
                tx_valid_d = 1'b1;
                sum_d      = sum_q ^ fifo_dout;
                cnt_d      = cnt_q + CNT_W'(1);
                state_d    = StSend;
            end
            StSend: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = StRdReq;
                end
            end
            StDiscard: begin
                // trunc_q is already set here, so the trailer word carries it.
                if (fifo_empty) begin
                    tx_data_d  = trl_cnt_word;
                    tx_valid_d = 1'b1;
                    state_d    = StTrlCnt;
                end else begin
                    fifo_rd = 1'b1;
                end
            end
            StTrlCnt: begin
                if (hs) begin
                    tx_data_d = sum_q;
                    tx_last_d = 1'b1;
                    state_d   = StTrlSum;
                end
            end
            StTrlSum: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    evt_d      = evt_q + 16'd1;
                    cnt_d      = '0;
                    sum_d      = '0;
                    trunc_d    = 1'b0;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (!rdy_level) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // An aborting reset must not pop a word the frame will never send.
        if (rst) begin
            fifo_rd = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            sum_q      <= '0;
            cnt_q      <= '0;
            trunc_q    <= 1'b0;
            evt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            trunc_q    <= trunc_d;
            evt_q      <= evt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;
    assign busy      = (state_q != StIdle);
    assign evt_count = evt_q;

endmodule

// File: tb/tb_event_readout_ctrl.sv
// Scoreboard bench for event_readout_ctrl: expected link words are queued by the
// stimulus and popped by a monitor on every accepted transfer.
module tb_event_readout_ctrl;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        event_rdy  = 1'b0;
    logic        fifo_empty;
    logic [15:0] fifo_dout  = '0;
    logic        fifo_rd;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic [15:0] evt_count;

    logic        ready_drv  = 1'b1;
    logic        rand_en    = 1'b0;
    logic        rand_bit   = 1'b0;

    logic [15:0] mem [0:63];
    int          wr_ptr     = 0;
    int          rd_ptr     = 0;
    int          rd_pulses  = 0;

    logic [16:0] exp_q [$];
    int          n_cmp      = 0;
    int          n_err      = 0;
    logic        stalled    = 1'b0;
    logic [15:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    event_readout_ctrl #(
        .DATA_W    (16),
        .MAX_WORDS (4),
        .SYNC_WORD (16'hA55A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .event_rdy  (event_rdy),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .busy       (busy),
        .evt_count  (evt_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign tx_ready   = rand_en ? rand_bit : ready_drv;

    // Standard-mode FIFO: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        rand_bit <= 1'($urandom_range(0, 1));
        if (fifo_rd && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
        if (fifo_rd) begin
            rd_pulses <= rd_pulses + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic monitor();
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_hold", {14'b0, tx_valid, tx_last, tx_data},
                          {14'b0, 1'b1, prev_last, prev_data});
                end
                if (fifo_rd) begin
                    check("rd_while_empty", {31'b0, fifo_empty}, 32'd0);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_word: got %0h last %0b, expected none",
                                 tx_data, tx_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", {15'b0, tx_last, tx_data}, {15'b0, e});
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = tx_valid;
                end
                prev_data = tx_data;
                prev_last = tx_last;
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 2000 && !(exp_q.size() == 0 && !tx_valid)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'b0, (n < 2000)}, 32'd1);
        #1;
    endtask

    task automatic wait_until_valid(input string name);
        int n = 0;
        while (n < 200 && !tx_valid) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'b0, (n < 200)}, 32'd1);
    endtask

    initial begin
        int rdp;
        int n;
        fork
            monitor();
        join_none

        // Reset values
        rst = 1'b1;
        tick(3);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_last", {31'b0, tx_last}, 32'd0);
        check("rst_tx_data", {16'b0, tx_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_evt_count", {16'b0, evt_count}, 32'd0);
        check("rst_fifo_rd", {31'b0, fifo_rd}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Nominal frame, with rise latency and held-level checks
        load(16'h0001); load(16'h0002); load(16'h0004);
        push(16'hA55A, 0); push(16'h0000, 0); push(16'h0001, 0); push(16'h0002, 0);
        push(16'h0004, 0); push(16'h0003, 0); push(16'h0007, 1);
        event_rdy = 1'b1;
        tick(1);
        check("rise_latency_k", {31'b0, tx_valid}, 32'd0);
        tick(1);
        check("rise_latency_k1_valid", {31'b0, tx_valid}, 32'd1);
        check("rise_latency_k1_data", {16'b0, tx_data}, 32'h0000A55A);
        wait_done("nominal");
        check("nominal_evt_count", {16'b0, evt_count}, 32'd1);
        tick(20);
        check("held_busy", {31'b0, busy}, 32'd1);
        check("held_evt_count", {16'b0, evt_count}, 32'd1);
        event_rdy = 1'b0;
        tick(4);
        check("rearm_idle", {31'b0, busy}, 32'd0);

        // Empty event
        rdp = rd_pulses;
        push(16'hA55A, 0); push(16'h0001, 0); push(16'h0000, 0); push(16'h0000, 1);
        event_rdy = 1'b1;
        wait_done("empty");
        check("empty_rd_pulses", rd_pulses - rdp, 32'd0);
        check("empty_evt_count", {16'b0, evt_count}, 32'd2);
        event_rdy = 1'b0;
        tick(4);

        // Backpressure: random tx_ready, same word sequence as nominal
        load(16'h0001); load(16'h0002); load(16'h0004);
        push(16'hA55A, 0); push(16'h0002, 0); push(16'h0001, 0); push(16'h0002, 0);
        push(16'h0004, 0); push(16'h0003, 0); push(16'h0007, 1);
        rand_en   = 1'b1;
        event_rdy = 1'b1;
        wait_done("backpressure");
        rand_en = 1'b0;
        check("bp_evt_count", {16'b0, evt_count}, 32'd3);
        event_rdy = 1'b0;
        tick(4);

        // Truncation: MAX_WORDS=4, six words queued
        load(16'h0010); load(16'h0020); load(16'h0040);
        load(16'h0080); load(16'h0100); load(16'h0200);
        rdp = rd_pulses;
        push(16'hA55A, 0); push(16'h0003, 0); push(16'h0010, 0); push(16'h0020, 0);
        push(16'h0040, 0); push(16'h0080, 0); push(16'h8004, 0); push(16'h00F0, 1);
        event_rdy = 1'b1;
        wait_done("trunc");
        check("trunc_fifo_empty", {31'b0, fifo_empty}, 32'd1);
        check("trunc_rd_pulses", rd_pulses - rdp, 32'd6);
        check("trunc_evt_count", {16'b0, evt_count}, 32'd4);
        event_rdy = 1'b0;
        tick(4);

        // Reset while word 2 is stalled in SEND
        load(16'h1111); load(16'h2222); load(16'h3333);
        push(16'hA55A, 0); push(16'h0004, 0); push(16'h1111, 0);
        event_rdy = 1'b1;
        n = 0;
        while (n < 200 && exp_q.size() != 0) begin
            @(negedge clk);
            n++;
        end
        check("rst_word1_timeout", {31'b0, (n < 200)}, 32'd1);
        @(posedge clk);
        #1;
        ready_drv = 1'b0;
        wait_until_valid("rst_word2");
        check("rst_word2_data", {16'b0, tx_data}, 32'h00002222);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        event_rdy = 1'b0;
        tick(1);
        check("abort_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("abort_tx_last", {31'b0, tx_last}, 32'd0);
        check("abort_tx_data", {16'b0, tx_data}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_evt_count", {16'b0, evt_count}, 32'd0);
        check("abort_fifo_rd", {31'b0, fifo_rd}, 32'd0);
        rst       = 1'b0;
        ready_drv = 1'b1;
        tick(3);
        check("abort_fifo_kept", {31'b0, fifo_empty}, 32'd0);
        push(16'hA55A, 0); push(16'h0000, 0); push(16'h3333, 0);
        push(16'h0001, 0); push(16'h3333, 1);
        event_rdy = 1'b1;
        wait_done("fresh");
        check("fresh_evt_count", {16'b0, evt_count}, 32'd1);
        event_rdy = 1'b0;
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
